// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern serializer / detector pair.
package pattern_pkg;

  // Serializer FSM states; the detector keeps its own typedef alongside this one.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2,
    StGap    = 2'd3
  } ser_state_t;

  // Serial line level between words; keeps the detector out of its match state.
  localparam logic PAT_IDLE_LVL = 1'b1;

endpackage

// File: rtl/pattern_shift_reg.sv
// Loadable WIDTH-bit shift register with selectable shift direction.
// sout is the head bit of the register's next contents, so a flop fed from it
// shows the bit in the same cycle the register holds it.
module pattern_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Next contents: load wins over shift. Rotating rather than shifting leaves
  // the word intact after a full pass.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], sr_q[WIDTH-1]} : {sr_q[0], sr_q[WIDTH-1:1]};
    end
  end

  // Register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sout = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];

endmodule

// File: rtl/pattern_bit_serializer.sv
// Parallel-to-serial feeder for the Moore pattern detector. Words arrive on a
// valid/ready handshake and leave one bit per clock on 'a'; the line idles high.
// Optional feature: define PATTERN_SER_PARITY_EN to append an even-parity bit.
module pattern_bit_serializer
  import pattern_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             a,
  output logic             a_valid,
  output logic             busy
);

  // One counter serves both the data bits and the gap.
  localparam int unsigned CntMax = (WIDTH > GAP_CYCLES + 1) ? WIDTH : GAP_CYCLES + 1;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] ShiftLoad = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] GapLoad   = (GAP_CYCLES > 0) ? CntW'(GAP_CYCLES - 1) : '0;

  ser_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            a_q, a_d;
  logic            a_valid_q, a_valid_d;
  logic            sr_load, sr_shift, sr_sout;
`ifdef PATTERN_SER_PARITY_EN
  logic            par_q, par_d;
`endif

  pattern_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST != 0)
  ) u_shift_reg (
    .clk  (clk),
    .reset(reset),
    .load (sr_load),
    .shift(sr_shift),
    .din  (din),
    .sout (sr_sout)
  );

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = PAT_IDLE_LVL;
    a_valid_d = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
`ifdef PATTERN_SER_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (din_valid) begin
          state_d   = StShift;
          cnt_d     = ShiftLoad;
          sr_load   = 1'b1;
          a_d       = sr_sout;
          a_valid_d = 1'b1;
`ifdef PATTERN_SER_PARITY_EN
          par_d     = ^din;
`endif
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - CntW'(1);
          sr_shift  = 1'b1;
          a_d       = sr_sout;
          a_valid_d = 1'b1;
        end else begin
`ifdef PATTERN_SER_PARITY_EN
          state_d   = StParity;
          a_d       = par_q;
          a_valid_d = 1'b1;
`else
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end else begin
            state_d = StIdle;
          end
`endif
        end
      end
      StParity: begin
`ifdef PATTERN_SER_PARITY_EN
        if (GAP_CYCLES > 0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= PAT_IDLE_LVL;
      a_valid_q <= 1'b0;
`ifdef PATTERN_SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
`ifdef PATTERN_SER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign din_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign a         = a_q;
  assign a_valid   = a_valid_q;

endmodule

// File: tb/tb_pattern_bit_serializer.sv
// Directed bench for pattern_bit_serializer: an MSB-first instance without gap
// and an LSB-first instance with a 2-cycle gap, both checked against a bit queue.
module tb_pattern_bit_serializer;

  localparam int unsigned W = 8;
`ifdef PATTERN_SER_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned GapL = 2;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din_m = '0, din_l = '0;
  logic         vld_m = 1'b0, vld_l = 1'b0;
  logic         rdy_m, a_m, av_m, busy_m;
  logic         rdy_l, a_l, av_l, busy_l;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  int last_m = 0, last_l = 0;
  int hs, hs2;
  logic q_m[$];
  logic q_l[$];

  pattern_bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_m (
    .clk(clk), .reset(reset), .din(din_m), .din_valid(vld_m), .din_ready(rdy_m),
    .a(a_m), .a_valid(av_m), .busy(busy_m)
  );

  pattern_bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .GAP_CYCLES(GapL)) dut_l (
    .clk(clk), .reset(reset), .din(din_l), .din_valid(vld_l), .din_ready(rdy_l),
    .a(a_l), .a_valid(av_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid bit pops the queue; an idle line must sit high.
  always @(negedge clk) begin
    if (mon_en) begin
      if (av_m) begin
        if (q_m.size() == 0) chk("m_unexpected_bit", av_m, 0);
        else begin
          chk("m_bit", a_m, q_m.pop_front());
          last_m = cyc;
        end
      end else chk("m_idle_level", a_m, 1);
      if (av_l) begin
        if (q_l.size() == 0) chk("l_unexpected_bit", av_l, 0);
        else begin
          chk("l_bit", a_l, q_l.pop_front());
          last_l = cyc;
        end
      end else chk("l_idle_level", a_l, 1);
    end
  end

  task automatic push_word(input bit sel, input logic [W-1:0] w);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = sel ? w[i] : w[W-1-i];
      if (sel) q_l.push_back(b);
      else q_m.push_back(b);
    end
    if (P != 0) begin
      b = 1'b0;
      for (int i = 0; i < W; i++) b = b ^ w[i];
      if (sel) q_l.push_back(b);
      else q_m.push_back(b);
    end
  endtask

  // Called just after a posedge; returns the cycle number of the handshake edge.
  task automatic handshake(input bit sel, input logic [W-1:0] w, output int hs_cyc);
    int n = 0;
    if (sel) begin din_l = w; vld_l = 1'b1; end
    else begin din_m = w; vld_m = 1'b1; end
    while (!(sel ? rdy_l : rdy_m) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_wait", n < 50, 1);
    @(posedge clk);
    push_word(sel, w);
    #1;
    hs_cyc = cyc;
    chk("busy_after_hs", sel ? busy_l : busy_m, 1);
    chk("ready_after_hs", sel ? rdy_l : rdy_m, 0);
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    while ((sel ? q_l.size() : q_m.size()) != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(sel ? "l_drain" : "m_drain", sel ? q_l.size() : q_m.size(), 0);
  endtask

  initial begin
    // Reset for two cycles.
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_a_m", a_m, 1);       chk("rst_av_m", av_m, 0);
    chk("rst_busy_m", busy_m, 0); chk("rst_rdy_m", rdy_m, 1);
    chk("rst_a_l", a_l, 1);       chk("rst_av_l", av_l, 0);
    chk("rst_busy_l", busy_l, 0); chk("rst_rdy_l", rdy_l, 1);

    // MSB-first A5: first bit in the cycle after the handshake.
    handshake(1'b0, 8'hA5, hs);
    vld_m = 1'b0;
    din_m = W'($urandom);
    @(negedge clk);
    chk("m_first_valid", av_m, 1);
    drain(1'b0);
    chk("m_last_bit_cycle", last_m - hs, W + P - 1);
    @(negedge clk);
    chk("m_end_valid", av_m, 0);
    chk("m_end_busy", busy_m, 0);

    // LSB-first 01.
    @(posedge clk); #1;
    handshake(1'b1, 8'h01, hs);
    vld_l = 1'b0;
    @(negedge clk);
    chk("l_first_valid", av_l, 1);
    drain(1'b1);
    chk("l_last_bit_cycle", last_l - hs, W + P - 1);

    // Odd population word for the parity bit.
    @(posedge clk); #1;
    handshake(1'b0, 8'h07, hs);
    vld_m = 1'b0;
    drain(1'b0);

    // Back-to-back with valid held high; din changes while busy must be ignored.
    repeat (4) @(posedge clk);
    #1;
    handshake(1'b1, 8'hC3, hs);
    din_l = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    chk("l_busy_mid", busy_l, 1);
    din_l = 8'h00;
    handshake(1'b1, 8'h5A, hs2);
    vld_l = 1'b0;
    chk("l_hs_spacing", hs2 - hs, 1 + W + P + GapL);
    drain(1'b1);

    // Reset at bit 4 of F0, with a word offered during reset.
    @(posedge clk); #1;
    handshake(1'b0, 8'hF0, hs);
    vld_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    q_m.delete();
    q_l.delete();
    #1;
    chk("mid_rst_a", a_m, 1);
    chk("mid_rst_av", av_m, 0);
    chk("mid_rst_busy", busy_m, 0);
    din_m = 8'h3C;
    vld_m = 1'b1;
    @(posedge clk); #1;
    chk("rst_wins_busy", busy_m, 0);
    chk("rst_wins_rdy", rdy_m, 1);
    reset = 1'b0;
    handshake(1'b0, 8'h3C, hs);
    vld_m = 1'b0;
    drain(1'b0);
    chk("m_3c_last_bit_cycle", last_m - hs, W + P - 1);

    repeat (3) @(posedge clk);
    #1;
    chk("final_q_m", q_m.size(), 0);
    chk("final_q_l", q_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_bit_serializer.md
# pattern_bit_serializer

Upstream feeder for the Moore pattern detector. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single serial line `a`, which drives the detector's `a` input directly. Between words the line idles high. A high idle keeps the detector out of its match state, so the only matches it reports come from word bits. An optional even-parity bit can be appended to each word.

## Interface
- `WIDTH`, default 8: data word width in bits; ≥2.
- `MSB_FIRST`, default 1: 1 sends bit `WIDTH-1` first; 0 sends bit 0 first.
- `GAP_CYCLES`, default 0: extra idle-high cycles inserted after each word; ≥0.

- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `din`, input, `WIDTH`: parallel word; sampled only on handshake.
- `din_valid`, input, 1: upstream offers `din`.
- `din_ready`, output, 1: block can accept a word.
- `a`, output, 1: serial bit to the detector; registered.
- `a_valid`, output, 1: high while `a` carries a data or parity bit; registered.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: `din_ready`=1, `a`=1, `a_valid`=0.
  - SHIFT: `WIDTH` cycles of data bits.
  - PARITY: 1 cycle; present only with the macro defined.
  - GAP: `GAP_CYCLES` cycles, `a`=1, `a_valid`=0.
- Transitions:
  - IDLE→SHIFT when `din_valid && din_ready` at the edge. `din` is captured into the shift register and the bit counter is loaded with `WIDTH-1`.
  - SHIFT: emits one bit per cycle and decrements the counter. When the counter reaches 0 it goes to PARITY (if enabled), else GAP (if `GAP_CYCLES`>0), else IDLE.
  - PARITY→GAP, or →IDLE if `GAP_CYCLES`=0.
  - GAP→IDLE after `GAP_CYCLES` cycles, counted by the same counter.
- `din_ready` is a decode of state == IDLE. A word is never accepted mid-word.
- `din` and `din_valid` are ignored outside IDLE. `din` may change freely after the handshake.
- Dropping `din_valid` without a handshake has no effect.
- Parity bit is the XOR of all `WIDTH` data bits (even parity over data+parity).
- Bit counter width is `$clog2(max(WIDTH, GAP_CYCLES+1))`. It wraps only by reload, never by overflow.

## Timing
- Reset values, from the cycle after `reset` is sampled high:
  - state IDLE, `a`=1, `a_valid`=0, `busy`=0, `din_ready`=1.
  - Shift register and counter are 0.
- Handshake at edge t:
  - First bit on `a` with `a_valid`=1 during cycle t+1.
  - Last data bit during cycle t+`WIDTH`.
  - Parity, when enabled, during cycle t+`WIDTH`+1.
- Word period, handshake to next possible handshake: 1 + `WIDTH` + P + `GAP_CYCLES` cycles, where P=1 with parity and 0 without. Back-to-back words are always separated by at least one idle-high cycle (the IDLE cycle).
- Reset mid-word: the word is abandoned, and the reset values apply on the next cycle. No partial bits follow.
- `reset` and `din_valid` high together: reset wins and no word is captured.

## Configuration
- `PATTERN_SER_PARITY_EN` defined: PARITY state present, and one even-parity bit is sent after each word.
- Not defined: no PARITY state and no parity logic. SHIFT goes directly to GAP/IDLE and the word period loses one cycle.

## Structure
- Shared package `pattern_pkg`:
  - state enum typedef `ser_state_t` (IDLE, SHIFT, PARITY, GAP);
  - the idle line level constant `PAT_IDLE_LVL = 1'b1`.
- The detector uses the same package for its own state typedef.
- One sub-module: `pattern_shift_reg`. It is a loadable `WIDTH`-bit shift register with a direction parameter (`MSB_FIRST`) and a serial-out port. FSM, counter and parity stay in the top.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-stream, then release.
  - Expect `a`=1, `a_valid`=0, `busy`=0, `din_ready`=1 on the first cycle after reset.
- **MSB-first, no parity:** `WIDTH`=8, `MSB_FIRST`=1, `din`=8'hA5, one handshake.
  - `a` = 1,0,1,0,0,1,0,1 on cycles t+1..t+8 with `a_valid`=1, then `a`=1, `a_valid`=0.
- **LSB-first:** `MSB_FIRST`=0, `din`=8'h01.
  - `a` = 1,0,0,0,0,0,0,0, then idle 1.
  - With the detector attached, `y` stays 0.
- **Parity, macro defined:** `din`=8'hA5 → parity bit 0 on cycle t+9. `din`=8'h07 → parity bit 1.
- **Back-to-back with gap:** `GAP_CYCLES`=2, `din_valid` held high with two words.
  - Handshakes are exactly 11 cycles apart (12 with parity).
  - `din` changes while `busy`=1 are ignored.
- **Reset mid-word:** `reset` at bit 4 of 8'hF0.
  - Next cycle `a`=1, `busy`=0.
  - A new word 8'h3C is accepted and sent intact.
